// File: rtl/calf_brouter.sv
// calf_brouter: bufferless CALF deflection router, 4 mesh ports + local port, registered outputs (1-cycle traversal).
// Mesh flits are never stalled; local injection is gated by port4_ready/port4_ack. BROUTER_DEFLECT_CNT_EN adds deflect_cnt.
module calf_brouter #(
  parameter int MY_X = 0,
  parameter int MY_Y = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [143:0] port0_ci,
  input  logic [143:0] port1_ci,
  input  logic [143:0] port2_ci,
  input  logic [143:0] port3_ci,
  input  logic [143:0] port4_ci,
  output logic [143:0] port0_co,
  output logic [143:0] port1_co,
  output logic [143:0] port2_co,
  output logic [143:0] port3_co,
  output logic [143:0] port4_co,
  output logic         port4_ready,
`ifdef BROUTER_DEFLECT_CNT_EN
  output logic [15:0]  deflect_cnt,
`endif
  output logic         port4_ack
);

  localparam int W = 144;
  localparam logic [1:0] MX = 2'(MY_X);
  localparam logic [1:0] MY = 2'(MY_Y);
  localparam logic [3:0] ME = {MY, MX};

  logic [W-1:0] ci   [5];
  logic [W-1:0] nxt  [5];
  logic [W-1:0] co_q [5];

  assign ci[0] = port0_ci;
  assign ci[1] = port1_ci;
  assign ci[2] = port2_ci;
  assign ci[3] = port3_ci;
  assign ci[4] = port4_ci;

  // Output index 0..3 = mesh, 4 = eject, 7 = nothing free (only possible for an unacked local flit).
  function automatic logic [2:0] route(input logic [3:0] dst, input logic [3:0] busy, input logic ej_busy);
    logic [2:0] p;
    logic       found;
    p     = 3'd7;
    found = 1'b0;
    if (dst == ME && !ej_busy) begin p = 3'd4; found = 1'b1; end
    if (!found && dst[1:0] > MX && !busy[1]) begin p = 3'd1; found = 1'b1; end
    if (!found && dst[1:0] < MX && !busy[3]) begin p = 3'd3; found = 1'b1; end
    if (!found && dst[3:2] > MY && !busy[2]) begin p = 3'd2; found = 1'b1; end
    if (!found && dst[3:2] < MY && !busy[0]) begin p = 3'd0; found = 1'b1; end
    for (int k = 0; k < 4; k++) begin
      if (!found && !busy[k]) begin p = 3'(k); found = 1'b1; end
    end
    return p;
  endfunction

`ifdef BROUTER_DEFLECT_CNT_EN
  logic [2:0] ndefl;

  function automatic logic productive(input logic [3:0] dst, input logic [1:0] p);
    case (p)
      2'd0:    return dst[3:2] < MY;
      2'd1:    return dst[1:0] > MX;
      2'd2:    return dst[3:2] > MY;
      default: return dst[1:0] < MX;
    endcase
  endfunction
`endif

  always_comb begin
    logic [3:0] busy;
    logic       ej;
    logic [2:0] sel;
    busy        = 4'h0;
    ej          = 1'b0;
    sel         = 3'd7;
    port4_ready = 1'b0;
    port4_ack   = 1'b0;
`ifdef BROUTER_DEFLECT_CNT_EN
    ndefl       = 3'd0;
`endif
    for (int k = 0; k < 5; k++) nxt[k] = '0;
    for (int i = 0; i < 5; i++) begin
      // The local flit goes last, so its acceptance depends on what the mesh flits left free.
      if (i == 4) begin
        port4_ready = (busy != 4'hF) || (ci[4][3:0] == ME && !ej);
        port4_ack   = ci[4][11] & port4_ready;
      end
      if (ci[i][11] && (i < 4 || port4_ack)) begin
        sel = route(ci[i][3:0], busy, ej);
        if (sel == 3'd4) begin
          ej     = 1'b1;
          nxt[4] = ci[i];
        end else if (sel < 3'd4) begin
          busy[sel[1:0]] = 1'b1;
          nxt[sel[1:0]]  = ci[i];
`ifdef BROUTER_DEFLECT_CNT_EN
          if (!productive(ci[i][3:0], sel[1:0])) ndefl = ndefl + 3'd1;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 5; k++) co_q[k] <= '0;
    end else begin
      for (int k = 0; k < 5; k++) co_q[k] <= nxt[k];
    end
  end

`ifdef BROUTER_DEFLECT_CNT_EN
  logic [16:0] cnt_sum;
  assign cnt_sum = {1'b0, deflect_cnt} + 17'(ndefl);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) deflect_cnt <= 16'h0;
    else      deflect_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end
`endif

  assign port0_co = co_q[0];
  assign port1_co = co_q[1];
  assign port2_co = co_q[2];
  assign port3_co = co_q[3];
  assign port4_co = co_q[4];

endmodule

// File: tb/tb_calf_brouter.sv
// Bench for calf_brouter: directed steps plus random traffic against a port-ownership reference model,
// on two routers (0,0) and (2,1) fed the same flits.
module tb_calf_brouter;

  logic         clk;
  logic         rst;
  logic [143:0] fl [5];
  logic [143:0] o0 [5];
  logic [143:0] o1 [5];
  logic         rdy0, ack0, rdy1, ack1;
`ifdef BROUTER_DEFLECT_CNT_EN
  logic [15:0]  cnt0, cnt1;
`endif

  int checks = 0;
  int errors = 0;

  logic [143:0] ex [5];
  logic [143:0] e0 [5];
  logic [143:0] e1 [5];
  bit           rdy_m, ack_m;
  int           nd_m;
  int           cnt0_m, cnt1_m;
  logic         r0_obs, a0_obs;

  calf_brouter #(.MY_X(0), .MY_Y(0)) u0 (
    .clk(clk), .rst(rst),
    .port0_ci(fl[0]), .port1_ci(fl[1]), .port2_ci(fl[2]), .port3_ci(fl[3]), .port4_ci(fl[4]),
    .port0_co(o0[0]), .port1_co(o0[1]), .port2_co(o0[2]), .port3_co(o0[3]), .port4_co(o0[4]),
    .port4_ready(rdy0),
`ifdef BROUTER_DEFLECT_CNT_EN
    .deflect_cnt(cnt0),
`endif
    .port4_ack(ack0)
  );

  calf_brouter #(.MY_X(2), .MY_Y(1)) u1 (
    .clk(clk), .rst(rst),
    .port0_ci(fl[0]), .port1_ci(fl[1]), .port2_ci(fl[2]), .port3_ci(fl[3]), .port4_ci(fl[4]),
    .port0_co(o1[0]), .port1_co(o1[1]), .port2_co(o1[2]), .port3_co(o1[3]), .port4_co(o1[4]),
    .port4_ready(rdy1),
`ifdef BROUTER_DEFLECT_CNT_EN
    .deflect_cnt(cnt1),
`endif
    .port4_ack(ack1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Owner-of-each-output model: mesh flits claim ports in input order, then the local flit.
  task automatic model(input int mx, input int my);
    int owner [5];
    int pref [$];
    bit done;
    int x, y;
    for (int p = 0; p < 5; p++) owner[p] = -1;
    nd_m = 0; rdy_m = 0; ack_m = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        for (int p = 0; p < 4; p++) if (owner[p] < 0) rdy_m = 1;
        if (int'(fl[4][3:0]) == my * 4 + mx && owner[4] < 0) rdy_m = 1;
        ack_m = fl[4][11] && rdy_m;
      end
      if (fl[i][11] && (i < 4 || ack_m)) begin
        x = int'(fl[i][1:0]);
        y = int'(fl[i][3:2]);
        if (x == mx && y == my && owner[4] < 0) owner[4] = i;
        else begin
          pref.delete();
          if (x > mx) pref.push_back(1);
          if (x < mx) pref.push_back(3);
          if (y > my) pref.push_back(2);
          if (y < my) pref.push_back(0);
          done = 0;
          foreach (pref[k]) if (!done && owner[pref[k]] < 0) begin owner[pref[k]] = i; done = 1; end
          for (int p = 0; p < 4; p++) if (!done && owner[p] < 0) begin owner[p] = i; done = 1; nd_m++; end
        end
      end
    end
    for (int p = 0; p < 5; p++) ex[p] = (owner[p] >= 0) ? fl[owner[p]] : 144'h0;
  endtask

  function automatic int sat_add(input int a, input int b);
    return (a + b > 65535) ? 65535 : a + b;
  endfunction

  // Inputs already driven; check combinational handshake, take one edge, check registered outputs.
  task automatic step();
    #1;
    model(0, 0);
    for (int p = 0; p < 5; p++) e0[p] = ex[p];
    chk("u0_ready", {143'h0, rdy0}, {143'h0, rdy_m});
    chk("u0_ack", {143'h0, ack0}, {143'h0, ack_m});
    cnt0_m = sat_add(cnt0_m, nd_m);
    model(2, 1);
    for (int p = 0; p < 5; p++) e1[p] = ex[p];
    chk("u1_ready", {143'h0, rdy1}, {143'h0, rdy_m});
    chk("u1_ack", {143'h0, ack1}, {143'h0, ack_m});
    cnt1_m = sat_add(cnt1_m, nd_m);
    r0_obs = rdy0;
    a0_obs = ack0;
    @(posedge clk);
    #1;
    for (int p = 0; p < 5; p++) begin
      chk($sformatf("u0_co%0d", p), o0[p], e0[p]);
      chk($sformatf("u1_co%0d", p), o1[p], e1[p]);
    end
`ifdef BROUTER_DEFLECT_CNT_EN
    chk("u0_cnt", {128'h0, cnt0}, 144'(cnt0_m));
    chk("u1_cnt", {128'h0, cnt1}, 144'(cnt1_m));
`endif
  endtask

  task automatic zero_in();
    for (int p = 0; p < 5; p++) fl[p] = 144'h0;
  endtask

  task automatic chk_all_zero(input string tag);
    for (int p = 0; p < 5; p++) begin
      chk($sformatf("%s_u0_co%0d", tag, p), o0[p], 144'h0);
      chk($sformatf("%s_u1_co%0d", tag, p), o1[p], 144'h0);
    end
  endtask

  localparam logic [143:0] F0 = 144'h0123456789abcdef012345789abcdef1857;
  localparam logic [143:0] F1 = 144'h00fedcba98765432100fedcba9876543284c;

  initial begin
    int r;
    cnt0_m = 0; cnt1_m = 0;

    // Reset held with valid traffic on every input.
    rst = 1'b0;
    fl[0] = F0; fl[1] = F1; fl[2] = F0; fl[3] = F1;
    fl[4] = {128'h5, 16'h0803};
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("rst_hold");
    rst = 1'b1;
    zero_in();
    step();
    chk_all_zero("rst_idle");

    // Two-flit route, then drain.
    fl[0] = F0; fl[1] = F1;
    step();
    chk("two_p1", o0[1], F0);
    chk("two_p2", o0[2], F1);
    chk("two_p0", o0[0], 144'h0);
    chk("two_p3", o0[3], 144'h0);
    chk("two_p4", o0[4], 144'h0);
    chk("two_rdy", {143'h0, r0_obs}, 144'h1);
    zero_in();
    step();
    chk_all_zero("two_drain");

    // Deflection: both want E only.
    fl[0] = {128'h1111_2222_3333_4444, 16'h0801};
    fl[1] = {128'haaaa_bbbb_cccc_dddd, 16'h0801};
    step();
    chk("defl_p1", o0[1], {128'h1111_2222_3333_4444, 16'h0801});
    chk("defl_p0", o0[0], {128'haaaa_bbbb_cccc_dddd, 16'h0801});
`ifdef BROUTER_DEFLECT_CNT_EN
    chk("defl_cnt", {128'h0, cnt0}, 144'h1);
`endif

    // Ejection contention.
    zero_in();
    fl[0] = {128'h0e0, 16'h0800};
    fl[2] = {128'h0e2, 16'h0800};
    step();
    chk("ej_p4", o0[4], {128'h0e0, 16'h0800});
    chk("ej_p0", o0[0], {128'h0e2, 16'h0800});

    // Injection blocked, then accepted once a mesh input drops.
    fl[0] = {128'h10, 16'h0805};
    fl[1] = {128'h11, 16'h0806};
    fl[2] = {128'h12, 16'h0809};
    fl[3] = {128'h13, 16'h080a};
    fl[4] = {128'h14, 16'h0803};
    step();
    chk("blk_rdy", {143'h0, r0_obs}, 144'h0);
    chk("blk_ack", {143'h0, a0_obs}, 144'h0);
    fl[3] = 144'h0;
    step();
    chk("inj_ack", {143'h0, a0_obs}, 144'h1);
    chk("inj_p3", o0[3], {128'h14, 16'h0803});

    // Invalid non-zero flit is ignored.
    zero_in();
    fl[0] = {128'hdead_beef, 16'h07ff};
    step();
    chk_all_zero("inval");

    // Reset asserted mid-cycle clears outputs without waiting for an edge.
    zero_in();
    fl[0] = F0; fl[1] = F1;
    step();
    rst = 1'b0;
    #1;
    chk_all_zero("rst_mid");
`ifdef BROUTER_DEFLECT_CNT_EN
    chk("rst_mid_cnt", {128'h0, cnt0}, 144'h0);
`endif
    cnt0_m = 0; cnt1_m = 0;
    zero_in();
    #1;
    rst = 1'b1;

    // Random traffic: empty, invalid-but-nonzero and valid flits on every port.
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < 5; p++) begin
        r = int'($urandom_range(0, 3));
        fl[p] = {$urandom(), $urandom(), $urandom(), $urandom(), 16'($urandom())};
        if (r == 0) fl[p] = 144'h0;
        else fl[p][11] = (r != 1);
      end
      step();
    end
    zero_in();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
